// File: rtl/hash_client_pkg.sv
// Shared constants for the hash-table stream client: op codes, response flag
// positions and the response word width.
package hash_client_pkg;

  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;

  localparam int unsigned FLAG_PRESENT   = 3;
  localparam int unsigned FLAG_NOT_FOUND = 2;
  localparam int unsigned FLAG_NO_SPACE  = 1;
  localparam int unsigned FLAG_NO_DEL    = 0;

  localparam int unsigned RSP_WIDTH = 64;
  localparam int unsigned FLAG_W    = 4;

  // A response is an error when any status flag is raised.
  function automatic logic any_flag(input logic [FLAG_W-1:0] flags);
    return |flags;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding {last, key} tags of requests awaiting a response.
// Push and pop may coincide, including when full.
module tag_fifo #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == CW'(0));
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hash_table_client.sv
// Host-side initiator for the hash-table stream port: forwards commands as
// requests, pairs in-order responses with their keys, and keeps statistics.
module hash_table_client
  import hash_client_pkg::*;
#(
  parameter int unsigned KEY_WIDTH       = 5,
  parameter int unsigned DATA_WIDTH      = 25,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        cmd_op_i,
  input  logic [KEY_WIDTH-1:0]              cmd_key_i,
  input  logic [DATA_WIDTH-1:0]             cmd_data_i,
  input  logic                              cmd_valid_i,
  input  logic                              cmd_last_i,
  output logic                              cmd_ready_o,
  output logic [2+DATA_WIDTH+KEY_WIDTH-1:0] req_data_o,
  output logic                              req_valid_o,
  output logic                              req_last_o,
  input  logic                              req_ready_i,
  input  logic [63:0]                       rsp_data_i,
  input  logic                              rsp_valid_i,
  output logic                              rsp_ready_o,
  output logic [KEY_WIDTH-1:0]              res_key_o,
  output logic [DATA_WIDTH-1:0]             res_data_o,
  output logic [3:0]                        res_flags_o,
  output logic                              res_last_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic [15:0]                       rsp_count_o,
  output logic [15:0]                       err_count_o,
  output logic                              orphan_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned TW = KEY_WIDTH + 1;

  logic          cmd_fire;
  logic          rsp_fire;
  logic          tag_pop;
  logic          tag_empty;
  logic          unused_tag_full;
  logic [TW-1:0] tag_head;
  logic [3:0]    rsp_flags;

  assign cmd_ready_o = (~req_valid_o | req_ready_i) & (outstanding_o < OW'(MAX_OUTSTANDING));
  assign rsp_ready_o = ~res_valid_o | res_ready_i;
  assign cmd_fire    = cmd_valid_i & cmd_ready_o;
  assign rsp_fire    = rsp_valid_i & rsp_ready_o;
  assign tag_pop     = rsp_fire & ~tag_empty;
  assign rsp_flags   = rsp_data_i[RSP_WIDTH-1 -: FLAG_W];

  generate
    if (DATA_WIDTH < 60) begin : g_unused_rsp
      logic unused_rsp_bits;
      assign unused_rsp_bits = ^rsp_data_i[59:DATA_WIDTH];
    end
  endgenerate

  tag_fifo #(
    .WIDTH (TW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_fire),
    .push_data ({cmd_last_i, cmd_key_i}),
    .pop       (tag_pop),
    .pop_data  (tag_head),
    .empty     (tag_empty),
    .full      (unused_tag_full)
  );

  // Request register: a new accept overrides a completing handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_data_o  <= '0;
      req_last_o  <= 1'b0;
      req_valid_o <= 1'b0;
    end else if (cmd_fire) begin
      req_data_o  <= {cmd_op_i, cmd_key_i, cmd_data_i};
      req_last_o  <= cmd_last_i;
      req_valid_o <= 1'b1;
    end else if (req_ready_i) begin
      req_valid_o <= 1'b0;
    end
  end

  // Result register: loads only when a tag is available to pair with.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_key_o   <= '0;
      res_data_o  <= '0;
      res_flags_o <= '0;
      res_last_o  <= 1'b0;
      res_valid_o <= 1'b0;
    end else if (tag_pop) begin
      res_key_o   <= tag_head[KEY_WIDTH-1:0];
      res_last_o  <= tag_head[KEY_WIDTH];
      res_data_o  <= rsp_data_i[DATA_WIDTH-1:0];
      res_flags_o <= rsp_flags;
      res_valid_o <= 1'b1;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_o <= '0;
      rsp_count_o   <= '0;
      err_count_o   <= '0;
      orphan_o      <= 1'b0;
    end else begin
      case ({cmd_fire, tag_pop})
        2'b10:   outstanding_o <= outstanding_o + OW'(1);
        2'b01:   outstanding_o <= outstanding_o - OW'(1);
        default: outstanding_o <= outstanding_o;
      endcase
      if (tag_pop) begin
        rsp_count_o <= rsp_count_o + 16'd1;
        if (any_flag(rsp_flags) && (err_count_o != 16'hFFFF))
          err_count_o <= err_count_o + 16'd1;
      end
      if (rsp_fire && tag_empty) orphan_o <= 1'b1;
    end
  end

endmodule

// File: doc/hash_table_client.md
# hash_table_client

Host-side initiator for the hash-table stream interface. It accepts commands from the host and drives them into the table's request port: a 2-bit op, a key and data, handled under the same valid/ready/last handshake. It receives the table's 64-bit response words, re-associates each response with the key that produced it, and decodes the status flags. It also keeps saturating statistics. It is the driver the top level places in front of the hash-table stream port.

## Interface
- KEY_WIDTH, 5: key width in bits.
- DATA_WIDTH, 25: data width in bits; must be ≤ 60.
- MAX_OUTSTANDING, 8: maximum requests in flight; power of two, ≥ 2. Also the depth of the tag FIFO.
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_op_i  in  2  op, passed through unchanged into request bits [top:top-1].
- cmd_key_i  in  KEY_WIDTH  command key.
- cmd_data_i  in  DATA_WIDTH  command data.
- cmd_valid_i / cmd_last_i  in  1  command handshake; last marks the end of a host burst.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- req_data_o  out  2+DATA_WIDTH+KEY_WIDTH  request word {op, key, data}.
- req_valid_o / req_last_o  out  1  request handshake.
- req_ready_i  in  1  table ready.
- rsp_data_i  in  64  response word:
  - [63] key_already_present, [62] no_element_found, [61] no_write_space, [60] no_deletion_target.
  - [DATA_WIDTH-1:0] read data.
- rsp_valid_i  in  1  response valid.
- rsp_ready_o  out  1  ready for a response.
- res_key_o  out  KEY_WIDTH  key of the returned response.
- res_data_o  out  DATA_WIDTH  read data.
- res_flags_o  out  4  rsp_data_i[63:60].
- res_last_o  out  1  last flag of the originating command.
- res_valid_o  out  1  result handshake valid.
- res_ready_i  in  1  result handshake ready.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  requests accepted but not yet responded to.
- rsp_count_o  out  16  responses consumed; wraps.
- err_count_o  out  16  responses with any flag set; saturates at 16'hFFFF.
- orphan_o  out  1  sticky: a response arrived with no request outstanding.

## Operation
- **Accept condition:** cmd_ready_o = (!req_valid_o | req_ready_i) & (outstanding_o < MAX_OUTSTANDING). It is combinational and independent of cmd_valid_i.
- **On command accept:**
  - The request register loads {op, key, data} and last; req_valid_o is set on the next cycle.
  - {key, last} is pushed into the tag FIFO.
  - outstanding increments.
- **Request register clear:** req_valid_o clears on a req handshake with no new accept in the same cycle.
- **Response ready:** rsp_ready_o = !res_valid_o | res_ready_i.
- **On response handshake with tag FIFO non-empty:**
  - Pop the tag FIFO.
  - Register the result: key and last from the tag, data from [DATA_WIDTH-1:0], flags from [63:60]. res_valid_o = 1.
  - outstanding decrements.
  - rsp_count_o increments.
  - err_count_o increments if any flag bit is set.
- **On response handshake with tag FIFO empty:**
  - The word is consumed and dropped.
  - orphan_o sets; counters and outstanding do not change.
- **Simultaneous accept and response:** outstanding is unchanged; the FIFO pushes and pops in the same cycle.
- **FIFO full:** implied by outstanding_o == MAX_OUTSTANDING, which forces cmd_ready_o low.
- **Response order:** the table returns responses in request order; no reordering is performed.

## Timing
- Command to req_valid_o: 1 cycle. Response to res_valid_o: 1 cycle.
- Full throughput: one command and one response per cycle when downstream is ready.
- Request and result outputs hold stable while valid is high and ready is low.
- Reset values:
  - req_valid_o = 0, req_last_o = 0, req_data_o = 0.
  - res_valid_o = 0, all res_* = 0.
  - outstanding_o = 0, rsp_count_o = 0, err_count_o = 0, orphan_o = 0.
  - Tag FIFO empty.
- **Reset mid-operation:** all in-flight tags are discarded. After reset, responses to pre-reset requests count as orphans.
- **Wrap and saturation:** rsp_count_o wraps 16'hFFFF → 0. err_count_o holds at 16'hFFFF.

## Structure
- **Package hash_client_pkg:**
  - Op constants OP_READ = 2'b01, OP_WRITE = 2'b10, OP_DELETE = 2'b11.
  - Flag bit indices FLAG_PRESENT = 3, FLAG_NOT_FOUND = 2, FLAG_NO_SPACE = 1, FLAG_NO_DEL = 0.
  - RSP_WIDTH = 64.
- **Sub-module tag_fifo:** synchronous FIFO, width KEY_WIDTH+1, depth MAX_OUTSTANDING. It has push/pop/empty/full ports and supports push and pop in the same cycle, including when full.

## Test plan
- Reset, then one write of key 5'h03, data 25'h1ABCDE, last = 1:
  - req_data_o = {2'b10, 5'h03, 25'h1ABCDE} one cycle after accept.
  - Table answers 64'h0 → res_key_o = 5'h03, res_flags_o = 0, res_last_o = 1, err_count_o stays 0.
- Eight reads to keys 0..7 with req_ready_i = 0:
  - After the first accept, one request is held in the register with req_ready_i low; cmd_ready_o then drops because the request register is occupied.
  - Release req_ready_i and issue a ninth command while no responses return: after 8 accepts, outstanding_o = 8 and cmd_ready_o = 0.
  - Return 8 responses → keys 0..7 in order and outstanding_o = 0.
- Response 64'h4000_0000_0000_0000 to a read of key 5'h1F → res_flags_o = 4'b0100, err_count_o = 1.
- res_ready_i held low with a result pending → rsp_ready_o = 0, the result stays stable, and no FIFO pop occurs until res_ready_i rises.
- Command accept and response in the same cycle at outstanding = 3 → outstanding stays 3 and the tag order is preserved.
- Response with nothing outstanding → orphan_o = 1, rsp_count_o unchanged, res_valid_o stays 0. Reset then clears orphan_o.
